// File: rtl/mapa_ram_if.sv
// Game-map RAM bus: engine read/write port plus the free-running display scan port.
// The master side is the game engine / display scanner, the slave side is mapa_ram.
interface mapa_ram_if;
  logic       update_renable;
  logic [9:0] update_rx;
  logic [9:0] update_ry;
  logic [1:0] update_rdata;
  logic       update_wenable;
  logic [1:0] update_wdata;
  logic [9:0] update_wx;
  logic [9:0] update_wy;
  logic [9:0] disp_x;
  logic [9:0] disp_y;
  logic [1:0] disp_data;

  modport master (
    output update_renable, update_rx, update_ry,
    output update_wenable, update_wdata, update_wx, update_wy,
    output disp_x, disp_y,
    input  update_rdata, disp_data
  );

  modport slave (
    input  update_renable, update_rx, update_ry,
    input  update_wenable, update_wdata, update_wx, update_wy,
    input  disp_x, disp_y,
    output update_rdata, disp_data
  );
endinterface

// File: rtl/mapa_ram.sv
// 2-bit-per-cell game map with an engine read/write port and an independent display read port.
// Optional power-up clear sweep compiled in with `define MAPA_CLEAR_EN.
module mapa_ram #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30
) (
  input  logic        clk,
  input  logic        reset,
  mapa_ram_if.slave   bus,
  output logic        busy
);

  localparam int DEPTH = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int AW    = ($clog2(DEPTH) > 11) ? $clog2(DEPTH) : 11;
  localparam logic [9:0]    W10   = 10'(MAPA_WIDTH);
  localparam logic [9:0]    H10   = 10'(MAPA_HEIGHT);
  localparam logic [AW-1:0] W_AW  = AW'(MAPA_WIDTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  logic [1:0]    mem [0:DEPTH-1];
  logic          r_in, w_in, d_in;
  logic [AW-1:0] raddr, waddr, daddr;
  logic          clearing;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [1:0]    mem_wd;

  assign r_in  = (bus.update_rx < W10) && (bus.update_ry < H10);
  assign w_in  = (bus.update_wx < W10) && (bus.update_wy < H10);
  assign d_in  = (bus.disp_x    < W10) && (bus.disp_y    < H10);
  assign raddr = AW'(bus.update_ry) * W_AW + AW'(bus.update_rx);
  assign waddr = AW'(bus.update_wy) * W_AW + AW'(bus.update_wx);
  assign daddr = AW'(bus.disp_y)    * W_AW + AW'(bus.disp_x);

`ifdef MAPA_CLEAR_EN
  // state    | meaning
  // ST_CLEAR | sweeping 00 into every cell, engine port blocked
  // ST_READY | normal operation until the next reset
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST) begin
        state    <= ST_READY;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  assign clearing = (state == ST_CLEAR);

  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = bus.update_wdata;
    if (reset) begin
      if (clearing) begin
        mem_we = 1'b1;
        mem_wa = clr_addr;
        mem_wd = 2'b00;
      end else if (bus.update_wenable && w_in) begin
        mem_we = 1'b1;
      end
    end
  end
`else
  assign clearing = 1'b0;

  always_comb begin
    mem_we = reset && bus.update_wenable && w_in;
    mem_wa = waddr;
    mem_wd = bus.update_wdata;
  end
`endif

  assign busy = clearing;

  // Single write port; storage has no reset so a reset never disturbs map contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.update_rdata <= 2'b00;
    end else if (bus.update_renable) begin
      if (clearing)  bus.update_rdata <= 2'b00;
      else if (r_in) bus.update_rdata <= mem[raddr];
      else           bus.update_rdata <= 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                bus.disp_data <= 2'b00;
    else if (clearing || !d_in) bus.disp_data <= 2'b00;
    else                       bus.disp_data <= mem[daddr];
  end

endmodule

// File: tb/tb_mapa_ram.sv
// Randomized self-checking bench for mapa_ram against a cell-array model of the map.
// Also exercises the clear sweep when compiled with MAPA_CLEAR_EN.
module tb_mapa_ram;
  localparam int W = 40;
  localparam int H = 30;
  localparam int N = W * H;

  logic clk;
  logic reset;
  logic busy;
  mapa_ram_if bus();

  mapa_ram #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the map as a plain array of cell values.
  logic [1:0] m [0:N-1];
  int  exp_r = 0;
  int  exp_d = 0;
  int  clear_left = 0;
  bit  check_en = 0;

  function automatic bit in_map(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  always @(posedge clk) begin
    int rx, ry, wx, wy, dx, dy;
    rx = int'(bus.update_rx); ry = int'(bus.update_ry);
    wx = int'(bus.update_wx); wy = int'(bus.update_wy);
    dx = int'(bus.disp_x);    dy = int'(bus.disp_y);
    if (!reset) begin
      exp_r = 0;
      exp_d = 0;
`ifdef MAPA_CLEAR_EN
      clear_left = N;
`endif
    end else if (clear_left > 0) begin
      if (bus.update_renable) exp_r = 0;
      exp_d = 0;
      clear_left--;
      if (clear_left == 0)
        for (int i = 0; i < N; i++) m[i] = 2'b00;
    end else begin
      if (bus.update_renable) exp_r = in_map(rx, ry) ? int'(m[ry*W + rx]) : 3;
      exp_d = in_map(dx, dy) ? int'(m[dy*W + dx]) : 0;
      if (bus.update_wenable && in_map(wx, wy)) m[wy*W + wx] = bus.update_wdata;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("rdata", int'(bus.update_rdata), exp_r);
      chk("disp_data", int'(bus.disp_data), exp_d);
      chk("busy", int'(busy), (clear_left > 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.update_renable = 1'b0; bus.update_rx = '0; bus.update_ry = '0;
    bus.update_wenable = 1'b0; bus.update_wdata = '0;
    bus.update_wx = '0; bus.update_wy = '0;
    bus.disp_x = 10'd1023; bus.disp_y = 10'd1023;
  endtask

  task automatic write_cell(input int x, input int y, input int d);
    bus.update_wenable = 1'b1; bus.update_wx = 10'(x); bus.update_wy = 10'(y);
    bus.update_wdata = 2'(d);
    tick();
    bus.update_wenable = 1'b0;
  endtask

  task automatic read_cell(input int x, input int y);
    bus.update_renable = 1'b1; bus.update_rx = 10'(x); bus.update_ry = 10'(y);
    tick();
    bus.update_renable = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, hits, hit_ok;
    for (int i = 0; i < N; i++) m[i] = 2'b00;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check_en = 1;
    chk("reset_rdata", int'(bus.update_rdata), 0);
    chk("reset_disp", int'(bus.disp_data), 0);
    reset = 1'b1;

`ifdef MAPA_CLEAR_EN
    chk("busy_after_reset", int'(busy), 1);
    for (int i = 0; i < 600; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    count_busy(n);
    chk("sweep_restart_len", n, N);
    hits = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bus.disp_x = 10'(x); bus.disp_y = 10'(y);
        tick();
        if (bus.disp_data != 2'b00) hits++;
      end
    chk("nonzero_after_sweep", hits, 0);
    bus.disp_x = 10'd1023; bus.disp_y = 10'd1023;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    count_busy(n);
    chk("sweep_len", n, N);
`else
    chk("busy_tied_low", int'(busy), 0);
`endif

    // Engine-side clear: storage is not guaranteed after power-up.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) write_cell(x, y, 0);

    write_cell(10, 10, 1);
    read_cell(10, 10);
    chk("rd_10_10", int'(bus.update_rdata), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold", int'(bus.update_rdata), 1);
    end

    bus.update_wenable = 1'b1; bus.update_wx = 10'd5; bus.update_wy = 10'd3;
    bus.update_wdata = 2'b10;
    bus.update_renable = 1'b1; bus.update_rx = 10'd5; bus.update_ry = 10'd3;
    tick();
    chk("rbw_old", int'(bus.update_rdata), 0);
    bus.update_wenable = 1'b0;
    tick();
    chk("rbw_new", int'(bus.update_rdata), 2);
    bus.update_renable = 1'b0;

    read_cell(40, 0);
    chk("oor_x", int'(bus.update_rdata), 3);
    read_cell(0, 30);
    chk("oor_y", int'(bus.update_rdata), 3);
    write_cell(40, 0, 1);
    read_cell(0, 1);
    chk("alias_0_1", int'(bus.update_rdata), 0);

    write_cell(39, 29, 3);
    hits = 0; hit_ok = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bus.disp_x = 10'(x); bus.disp_y = 10'(y);
        tick();
        if (bus.disp_data == 2'b11) begin
          hits++;
          if (x == 39 && y == 29) hit_ok = 1;
        end
      end
    chk("disp_hits", hits, 1);
    chk("disp_hit_pos", hit_ok, 1);

    for (int i = 0; i < 4000; i++) begin
      bus.update_renable = 1'($urandom_range(0, 1));
      bus.update_rx = 10'($urandom_range(0, 44));
      bus.update_ry = 10'($urandom_range(0, 33));
      bus.update_wenable = 1'($urandom_range(0, 1));
      bus.update_wdata = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        bus.update_wx = bus.update_rx; bus.update_wy = bus.update_ry;
      end else begin
        bus.update_wx = 10'($urandom_range(0, 44));
        bus.update_wy = 10'($urandom_range(0, 33));
      end
      bus.disp_x = 10'($urandom_range(0, 44));
      bus.disp_y = 10'($urandom_range(0, 33));
      reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mapa_ram.md
MAPA_RAM -- requirements
Module: mapa_ram

Interface
REQ-001 The parameter list SHALL be: MAPA_WIDTH, 40, map cells per row; MAPA_HEIGHT, 30, map rows.
REQ-002 Port list, clock and reset first:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; one clock
- update_renable  in  1  game-engine read strobe
- update_rx  in  10  read cell x
- update_ry  in  10  read cell y
- update_rdata  out  2  read data
- update_wenable  in  1  game-engine write strobe
- update_wdata  in  2  write data: 00 empty, 01 snake, 10 fruit, 11 obstacle
- update_wx  in  10  write cell x
- update_wy  in  10  write cell y
- disp_x  in  10  display scan cell x
- disp_y  in  10  display scan cell y
- disp_data  out  2  display cell contents
- busy  out  1  high while the clear sweep runs

Function
REQ-003 Storage SHALL hold MAPA_WIDTH*MAPA_HEIGHT 2-bit cells, address = y*MAPA_WIDTH + x, computed at 11 bits minimum with no truncation for in-range coordinates.
REQ-004 Coordinate (x,y) SHALL be in range iff x < MAPA_WIDTH and y < MAPA_HEIGHT.
REQ-005 When update_wenable=1 and the coordinate is in range, the cell SHALL be written at the clock edge; out-of-range writes SHALL be discarded.
REQ-006 When update_renable=1, update_rdata SHALL present the cell contents exactly one clock later and SHALL hold that value until the next accepted read.
REQ-007 An out-of-range read SHALL return 2'b11, so the engine treats off-map cells as obstacles.
REQ-008 A read and a write to the same cell in the same cycle SHALL return the old contents (read-before-write); the new value SHALL be visible to reads issued on any later cycle.
REQ-009 The display port SHALL be read every cycle with no strobe: disp_data SHALL equal the contents of (disp_x,disp_y) one clock later; out-of-range display coordinates SHALL yield 2'b00.
REQ-010 The display and update ports SHALL be independent; neither SHALL stall or alter the other.
REQ-011 The controller SHALL have states CLEAR and READY: CLEAR→READY after the last address is written; READY SHALL persist until reset.
REQ-012 In CLEAR, one address per clock SHALL be written with 2'b00, ascending from 0 to MAPA_WIDTH*MAPA_HEIGHT-1; busy=1 throughout.
REQ-013 In CLEAR, update writes SHALL be ignored, and update reads and display reads SHALL return 2'b00.
REQ-014 busy SHALL fall on the clock edge that completes the final clear write, so the sweep lasts exactly MAPA_WIDTH*MAPA_HEIGHT cycles (1200 at defaults).

Reset
REQ-015 While reset=0 at a clock edge, the block SHALL set update_rdata=00, disp_data=00, the sweep counter to 0, and the state to CLEAR (busy=1) when MAPA_CLEAR_EN is defined, or READY (busy=0) otherwise.
REQ-016 Reset asserted during a sweep SHALL restart the sweep at address 0 after release.
REQ-017 Reset SHALL NOT otherwise modify storage contents.

Configuration
REQ-018 With MAPA_CLEAR_EN defined, the CLEAR sweep SHALL be compiled in and behave per REQ-011 to REQ-014.
REQ-019 Without MAPA_CLEAR_EN, CLEAR and the sweep counter SHALL be absent, busy SHALL be tied to 0, and storage contents after power-up SHALL be undefined; the game engine performs its own clear.

Verification
REQ-020 MAPA_CLEAR_EN defined, reset pulse → busy=1 for exactly 1200 cycles; afterwards every cell reads 00.
REQ-021 Write (10,10)=01, then on the next cycle read (10,10) → update_rdata=01 one clock after renable, and it holds while renable=0.
REQ-022 Same-cycle write (5,3)=10 and read (5,3) with prior contents 00 → rdata=00; re-read → 10.
REQ-023 Read (40,0) and (0,30) → 11; write (40,0)=01 → no cell changes, including (0,1) at alias address 40.
REQ-024 Write (39,29)=11; sweep disp_x/disp_y across the map → disp_data=11 only at (39,29), with one-cycle latency.
REQ-025 Assert reset at sweep address 600 → after release, busy stays high for a further full 1200 cycles.
